// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source select, load size and FSM state.
package wb_pkg;

  localparam logic [1:0] WB_SRC_ALU  = 2'd0;
  localparam logic [1:0] WB_SRC_MEM  = 2'd1;
  localparam logic [1:0] WB_SRC_LINK = 2'd2;
  localparam logic [1:0] WB_SRC_IO   = 2'd3;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the byte/half lane, extends it, flags misaligned accesses.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      size,
  input  logic            ld_unsigned,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [XLEN-1:0]    byte_sh;
  logic [XLEN-1:0]    half_sh;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic               ext_b;
  logic               ext_h;

  assign byte_sh = raw >> {addr_lo, 3'b000};
  assign half_sh = raw >> {addr_lo[1], 4'b0000};
  assign byte_s  = byte_sh[7:0];
  assign half_s  = half_sh[15:0];
  assign ext_b   = ~ld_unsigned & byte_s[7];
  assign ext_h   = ~ld_unsigned & half_s[15];

  always_comb begin
    data     = raw;
    misalign = 1'b0;
    case (size)
      LD_B: data = {{(XLEN-8){ext_b}}, byte_s};
      LD_H: begin
        data     = {{(XLEN-16){ext_h}}, half_s};
        misalign = addr_lo[0];
      end
      // LD_W and the reserved code both load the full word
      default: misalign = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Registered writeback stage between MEM and the register file.
// Optional macro WB_RETIRE_CNT_EN adds retire_cnt / misalign_cnt performance counters.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [1:0]         in_src,
  input  logic               in_we,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]    in_alu,
  input  logic [XLEN-1:0]    in_link,
  input  logic [XLEN-1:0]    in_io,
  input  logic [1:0]         in_ld_size,
  input  logic               in_ld_unsigned,
  input  logic [1:0]         in_addr_lo,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               misalign
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]        retire_cnt,
  output logic [31:0]        misalign_cnt
`endif
);

  wb_state_e          state, state_nxt;
  logic               accept;
  logic [XLEN-1:0]    sel_data;
  logic [XLEN-1:0]    ld_data;
  logic               ld_misalign;

  // Load context captured at accept, held through WAIT_MEM
  logic [RADDR_W-1:0] rd_p1;
  logic               we_p1;
  logic [1:0]         size_p1;
  logic               uns_p1;
  logic [1:0]         addr_lo_p1;
  logic               drop_p1;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_ready && in_valid && !flush;

  always_comb begin
    sel_data = in_alu;
    case (in_src)
      WB_SRC_LINK: sel_data = in_link;
      WB_SRC_IO:   sel_data = in_io;
      default:     sel_data = in_alu;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (accept && in_src == WB_SRC_MEM) state_nxt = ST_WAIT_MEM;
      ST_WAIT_MEM: if (mem_rvalid) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  wb_load_align #(.XLEN(XLEN)) u_align (
    .raw         (mem_rdata),
    .size        (size_p1),
    .ld_unsigned (uns_p1),
    .addr_lo     (addr_lo_p1),
    .data        (ld_data),
    .misalign    (ld_misalign)
  );

  // Stage p0 -> p1: payload capture, no reset needed
  always_ff @(posedge clk) begin
    if (accept && in_src == WB_SRC_MEM) begin
      rd_p1      <= in_rd;
      we_p1      <= in_we;
      size_p1    <= in_ld_size;
      uns_p1     <= in_ld_unsigned;
      addr_lo_p1 <= in_addr_lo;
    end
  end

  // Stage p1 -> register file: commit pulses and write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      misalign <= 1'b0;
      drop_p1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rf_we    <= 1'b0;
      misalign <= 1'b0;
      if (state == ST_IDLE) begin
        drop_p1 <= 1'b0;
        if (accept && in_src != WB_SRC_MEM) begin
          rf_we    <= in_we && (in_rd != '0);
          rf_waddr <= in_rd;
          rf_wdata <= sel_data;
        end
      end else begin
        if (flush) drop_p1 <= 1'b1;
        if (mem_rvalid) begin
          drop_p1 <= 1'b0;
          if (!(drop_p1 || flush)) begin
            if (ld_misalign) begin
              misalign <= 1'b1;
            end else begin
              rf_we    <= we_p1 && (rd_p1 != '0);
              rf_waddr <= rd_p1;
              rf_wdata <= ld_data;
            end
          end
        end
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt   <= '0;
      misalign_cnt <= '0;
    end else begin
      if (rf_we)    retire_cnt   <= retire_cnt + 64'd1;
      if (misalign) misalign_cnt <= sat_inc32(misalign_cnt);
    end
  end
`endif

endmodule
